amdc_gpio_mux_axi_slave: RTL and testbench
==========================================

# amdc_gpio_mux_axi_slave

AXI4-Lite responder holding the four 32-bit control registers of the AMDC GPIO mux IP. It sits between the PS interconnect (S00_AXI) and the mux datapath. It accepts single-beat writes and reads, applies byte strobes, and drives the register contents and per-register write pulses to the mux logic.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register and bits [1:0] are ignored.
- ACLK  in  1  sole clock; all logic rises on this edge.
- ARESETN  in  1  asynchronous, active-low reset; assertion is asynchronous, release is synchronous to ACLK.
- AWADDR / AWPROT / AWVALID  in  4 / 3 / 1  write address channel; AWPROT is ignored.
- AWREADY  out  1  write address accepted.
- WDATA / WSTRB / WVALID  in  32 / 4 / 1  write data channel.
- WREADY  out  1  write data accepted.
- BRESP / BVALID  out  2 / 1  write response; BRESP is always 2'b00 (OKAY).
- BREADY  in  1  master accepts the write response.
- ARADDR / ARPROT / ARVALID  in  4 / 3 / 1  read address channel; ARPROT is ignored.
- ARREADY  out  1  read address accepted.
- RDATA / RRESP / RVALID  out  32 / 2 / 1  read data; RRESP is always 2'b00.
- RREADY  in  1  master accepts the read data.
- reg0_o .. reg3_o  out  32 each  current register contents, fed to the mux datapath.
- reg_wr_pulse_o  out  4  one-cycle strobe; bit n is high for the single cycle after register n is committed.

## Operation
- Write FSM has two states, W_IDLE and W_RESP.
  - In W_IDLE: AWREADY = ready_en & !aw_held and WREADY = ready_en & !w_held.
  - AW and W handshakes are independent and may complete in either order or in the same cycle. Each handshake latches its payload and sets aw_held / w_held.
  - Commit happens on the edge where both channels are available, either latched or handshaking that cycle. At that edge:
    - the addressed register is updated bytewise per WSTRB;
    - the matching reg_wr_pulse_o bit is set;
    - BVALID is set, both held flags are cleared, and the FSM moves to W_RESP.
- In W_RESP: AWREADY and WREADY are 0. BVALID holds until BVALID & BREADY, then the FSM returns to W_IDLE.
- Read FSM has two states, R_IDLE and R_DATA.
  - In R_IDLE: ARREADY = ready_en.
  - On the handshake, RDATA is captured from the register selected by ARADDR[3:2], RVALID is set, and the FSM moves to R_DATA.
  - In R_DATA: ARREADY is 0. RDATA and RVALID stay stable until RVALID & RREADY, then the FSM returns to R_IDLE.
- Read and write paths are fully independent.
  - If a read capture and a write commit hit the same register on the same edge, RDATA returns the pre-write value.
- WSTRB = 4'b0000 completes a normal write with an OKAY response, leaves the register unchanged, and still pulses reg_wr_pulse_o.
- ready_en is a flop: reset to 0, set to 1 on the first ACLK edge after ARESETN releases, and held at 1 thereafter.

## Timing
- Reset values:
  - all ready and valid outputs are 0;
  - BRESP, RRESP and RDATA are 0;
  - reg0_o..reg3_o are 0x00000000;
  - reg_wr_pulse_o is 0;
  - both FSMs are idle and the held flags are clear.
- Write latency: BVALID and the register update are visible 1 cycle after the later of the AW and W handshakes.
- Write throughput: with BREADY held high, one write every 2 cycles.
- Read latency: RVALID is visible 1 cycle after the AR handshake. With RREADY high, one read every 2 cycles.
- Back-pressure: B and R outputs hold indefinitely while BREADY or RREADY is low, with no change to BRESP or RDATA.
- reg_wr_pulse_o is high for exactly 1 cycle per commit.
- Reset asserted mid-transaction:
  - the pending AW, W, B or R is dropped immediately;
  - no response is issued after reset releases;
  - the registers return to 0.

## Structure
- Package amdc_gpio_mux_pkg holds:
  - the register index constants (REG_CTRL0..REG_CTRL3 = 0..3);
  - the write-FSM and read-FSM state enums;
  - the OKAY response constant.
- One natural sub-module, amdc_gpio_mux_strb_merge: a combinational byte-strobe merge taking old data, WDATA and WSTRB and producing the new data. Everything else lives in a single module.

## Test plan
- Sequential writes of 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then reads of the same addresses → RDATA 0x1, 0x2, 0x3, 0x4, all responses OKAY, and reg_wr_pulse_o sequence 0001, 0010, 0100, 1000.
- W presented 3 cycles before AW (data 0xDEADBEEF, address 0x8) → WREADY drops after the W handshake, commit and BVALID come 1 cycle after the AW handshake, and reg2_o = 0xDEADBEEF.
- reg1 = 0xFFFFFFFF, then a write of 0x12345678 with WSTRB 0101 → reg1_o = 0xFF34FF78; a WSTRB 0000 write leaves the value unchanged but still pulses.
- BREADY and RREADY held low for 5 cycles → BVALID, RVALID and RDATA stay stable, AWREADY, WREADY and ARREADY stay 0, and everything completes when the ready signals rise.
- Same-edge read of 0x4 and write of 0xAA to 0x4 (old value 0x2) → RDATA 0x2, followed by a subsequent read returning 0xAA.
- ARESETN pulsed low while BVALID is pending → BVALID drops, all registers read 0, no stray B appears after release, and the readies are 0 in the first post-reset cycle.

Source files
------------

// File: rtl/amdc_gpio_mux_pkg.sv
// Shared constants and state types for the AMDC GPIO mux AXI4-Lite register block.
package amdc_gpio_mux_pkg;

   localparam logic [1:0] REG_CTRL0 = 2'd0;
   localparam logic [1:0] REG_CTRL1 = 2'd1;
   localparam logic [1:0] REG_CTRL2 = 2'd2;
   localparam logic [1:0] REG_CTRL3 = 2'd3;

   localparam int unsigned NUM_REGS = 4;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_RESP = 1'b1
   } wr_state_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_e;

   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/amdc_gpio_mux_strb_merge.sv
// Combinational byte-strobe merge: each strobed byte takes the new write data,
// every other byte keeps the old register contents.
module amdc_gpio_mux_strb_merge #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]   old_i,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic [DATA_W/8-1:0] wstrb_i,
   output logic [DATA_W-1:0]   new_o
);

   always_comb begin
      new_o = old_i;
      for (int b = 0; b < DATA_W/8; b++) begin
         if (wstrb_i[b]) begin
            new_o[b*8 +: 8] = wdata_i[b*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/amdc_gpio_mux_axi_slave.sv
// AXI4-Lite responder for the four AMDC GPIO mux control registers; drives the
// register contents and a one-cycle per-register write pulse to the mux datapath.
module amdc_gpio_mux_axi_slave
   import amdc_gpio_mux_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
   input  logic [2:0]                      AWPROT,
   input  logic                            AWVALID,
   output logic                            AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
   input  logic                            WVALID,
   output logic                            WREADY,
   output logic [1:0]                      BRESP,
   output logic                            BVALID,
   input  logic                            BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
   input  logic [2:0]                      ARPROT,
   input  logic                            ARVALID,
   output logic                            ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
   output logic [1:0]                      RRESP,
   output logic                            RVALID,
   input  logic                            RREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
   output logic [NUM_REGS-1:0]             reg_wr_pulse_o
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int SW = C_S_AXI_DATA_WIDTH / 8;

   wr_state_e         wr_state_q, wr_state_d;
   rd_state_e         rd_state_q, rd_state_d;
   logic              ready_en_q;
   logic              aw_held_q, aw_held_d;
   logic              w_held_q, w_held_d;
   logic [1:0]        aw_idx_q, aw_idx_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic [SW-1:0]     wstrb_q, wstrb_d;
   logic [DW-1:0]     regs_q [NUM_REGS];
   logic [DW-1:0]     regs_d [NUM_REGS];
   logic              bvalid_q, bvalid_d;
   logic              rvalid_q, rvalid_d;
   logic [DW-1:0]     rdata_q, rdata_d;
   logic [NUM_REGS-1:0] pulse_q, pulse_d;

   logic              awready, wready, arready;
   logic              aw_hs, w_hs, ar_hs;
   logic [1:0]        cm_idx;
   logic [DW-1:0]     cm_wdata, cm_merged;
   logic [SW-1:0]     cm_wstrb;

   // Commit payload comes from the latched copy if that channel already handshook,
   // otherwise straight from the bus in the handshake cycle.
   assign cm_idx   = aw_held_q ? aw_idx_q : AWADDR[3:2];
   assign cm_wdata = w_held_q  ? wdata_q  : WDATA;
   assign cm_wstrb = w_held_q  ? wstrb_q  : WSTRB;

   amdc_gpio_mux_strb_merge #(
      .DATA_W (DW)
   ) u_strb_merge (
      .old_i   (regs_q[cm_idx]),
      .wdata_i (cm_wdata),
      .wstrb_i (cm_wstrb),
      .new_o   (cm_merged)
   );

   always_comb begin
      wr_state_d = wr_state_q;
      aw_held_d  = aw_held_q;
      w_held_d   = w_held_q;
      aw_idx_d   = aw_idx_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      regs_d     = regs_q;
      bvalid_d   = bvalid_q;
      pulse_d    = '0;
      awready    = 1'b0;
      wready     = 1'b0;
      aw_hs      = 1'b0;
      w_hs       = 1'b0;
      case (wr_state_q)
         W_IDLE: begin
            awready = ready_en_q & ~aw_held_q;
            wready  = ready_en_q & ~w_held_q;
            aw_hs   = AWVALID & awready;
            w_hs    = WVALID & wready;
            if (aw_hs) begin
               aw_held_d = 1'b1;
               aw_idx_d  = AWADDR[3:2];
            end
            if (w_hs) begin
               w_held_d = 1'b1;
               wdata_d  = WDATA;
               wstrb_d  = WSTRB;
            end
            if ((aw_held_q | aw_hs) & (w_held_q | w_hs)) begin
               regs_d[cm_idx] = cm_merged;
               pulse_d        = reg_onehot(cm_idx);
               bvalid_d       = 1'b1;
               aw_held_d      = 1'b0;
               w_held_d       = 1'b0;
               wr_state_d     = W_RESP;
            end
         end
         W_RESP: begin
            if (BREADY) begin
               bvalid_d   = 1'b0;
               wr_state_d = W_IDLE;
            end
         end
         default: wr_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      rd_state_d = rd_state_q;
      rvalid_d   = rvalid_q;
      rdata_d    = rdata_q;
      arready    = 1'b0;
      ar_hs      = 1'b0;
      case (rd_state_q)
         R_IDLE: begin
            arready = ready_en_q;
            ar_hs   = ARVALID & arready;
            // regs_q is the pre-commit value, so a same-edge write is not seen here.
            if (ar_hs) begin
               rdata_d    = regs_q[ARADDR[3:2]];
               rvalid_d   = 1'b1;
               rd_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (RREADY) begin
               rvalid_d   = 1'b0;
               rd_state_d = R_IDLE;
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wr_state_q <= W_IDLE;
         rd_state_q <= R_IDLE;
      end else begin
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         ready_en_q <= 1'b0;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         pulse_q    <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         ready_en_q <= 1'b1;
         aw_held_q  <= aw_held_d;
         w_held_q   <= w_held_d;
         bvalid_q   <= bvalid_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         pulse_q    <= pulse_d;
         regs_q     <= regs_d;
      end
   end

   // Latched payload is only consumed while its held flag is set.
   always_ff @(posedge ACLK) begin
      aw_idx_q <= aw_idx_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
   end

   assign AWREADY        = awready;
   assign WREADY         = wready;
   assign ARREADY        = arready;
   assign BVALID         = bvalid_q;
   assign BRESP          = RESP_OKAY;
   assign RVALID         = rvalid_q;
   assign RDATA          = rdata_q;
   assign RRESP          = RESP_OKAY;
   assign reg0_o         = regs_q[REG_CTRL0];
   assign reg1_o         = regs_q[REG_CTRL1];
   assign reg2_o         = regs_q[REG_CTRL2];
   assign reg3_o         = regs_q[REG_CTRL3];
   assign reg_wr_pulse_o = pulse_q;

   logic unused_bits;
   assign unused_bits = ^{AWPROT, ARPROT, AWADDR, ARADDR};

endmodule

// File: tb/tb_amdc_gpio_mux_axi_slave.sv
// Directed bench for amdc_gpio_mux_axi_slave with hand-computed expected values.
module tb_amdc_gpio_mux_axi_slave;

   logic        ACLK;
   logic        ARESETN;
   logic [3:0]  AWADDR;
   logic [2:0]  AWPROT;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WVALID;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;
   logic [3:0]  ARADDR;
   logic [2:0]  ARPROT;
   logic        ARVALID;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID;
   logic        RREADY;
   logic [31:0] reg0_o, reg1_o, reg2_o, reg3_o;
   logic [3:0]  reg_wr_pulse_o;

   int n_chk  = 0;
   int n_fail = 0;

   amdc_gpio_mux_axi_slave #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (4)
   ) dut (
      .ACLK           (ACLK),
      .ARESETN        (ARESETN),
      .AWADDR         (AWADDR),
      .AWPROT         (AWPROT),
      .AWVALID        (AWVALID),
      .AWREADY        (AWREADY),
      .WDATA          (WDATA),
      .WSTRB          (WSTRB),
      .WVALID         (WVALID),
      .WREADY         (WREADY),
      .BRESP          (BRESP),
      .BVALID         (BVALID),
      .BREADY         (BREADY),
      .ARADDR         (ARADDR),
      .ARPROT         (ARPROT),
      .ARVALID        (ARVALID),
      .ARREADY        (ARREADY),
      .RDATA          (RDATA),
      .RRESP          (RRESP),
      .RVALID         (RVALID),
      .RREADY         (RREADY),
      .reg0_o         (reg0_o),
      .reg1_o         (reg1_o),
      .reg2_o         (reg2_o),
      .reg3_o         (reg3_o),
      .reg_wr_pulse_o (reg_wr_pulse_o)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic axi_write(input string tag, input logic [3:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [3:0] exp_pulse);
      int  cyc;
      logic aw_ok, w_ok;
      AWADDR = a; WDATA = d; WSTRB = s;
      AWVALID = 1'b1; WVALID = 1'b1;
      cyc = 0;
      while ((AWVALID || WVALID) && cyc < 20) begin
         @(negedge ACLK);
         aw_ok = AWVALID && AWREADY;
         w_ok  = WVALID && WREADY;
         tick();
         if (aw_ok) AWVALID = 1'b0;
         if (w_ok)  WVALID  = 1'b0;
         cyc++;
      end
      chk_eq({tag, "_hs_in_time"}, 32'(cyc < 20), 32'd1);
      AWVALID = 1'b0; WVALID = 1'b0;
      chk_eq({tag, "_bvalid"}, 32'(BVALID), 32'd1);
      chk_eq({tag, "_bresp"}, 32'(BRESP), 32'd0);
      chk_eq({tag, "_pulse"}, 32'(reg_wr_pulse_o), 32'(exp_pulse));
      BREADY = 1'b1;
      tick();
      BREADY = 1'b0;
      chk_eq({tag, "_bvalid_done"}, 32'(BVALID), 32'd0);
      chk_eq({tag, "_pulse_done"}, 32'(reg_wr_pulse_o), 32'd0);
   endtask

   task automatic axi_read(input string tag, input logic [3:0] a, input logic [31:0] exp);
      int  cyc;
      logic ar_ok;
      ARADDR = a; ARVALID = 1'b1;
      cyc = 0;
      while (ARVALID && cyc < 20) begin
         @(negedge ACLK);
         ar_ok = ARVALID && ARREADY;
         tick();
         if (ar_ok) ARVALID = 1'b0;
         cyc++;
      end
      chk_eq({tag, "_hs_in_time"}, 32'(cyc < 20), 32'd1);
      ARVALID = 1'b0;
      chk_eq({tag, "_rvalid"}, 32'(RVALID), 32'd1);
      chk_eq({tag, "_rresp"}, 32'(RRESP), 32'd0);
      chk_eq({tag, "_rdata"}, RDATA, exp);
      RREADY = 1'b1;
      tick();
      RREADY = 1'b0;
      chk_eq({tag, "_rvalid_done"}, 32'(RVALID), 32'd0);
   endtask

   initial begin
      ARESETN = 1'b0;
      AWADDR = '0; AWPROT = '0; AWVALID = 1'b0;
      WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
      ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;

      // Reset state
      repeat (3) tick();
      chk_eq("rst_awready", 32'(AWREADY), 32'd0);
      chk_eq("rst_wready", 32'(WREADY), 32'd0);
      chk_eq("rst_arready", 32'(ARREADY), 32'd0);
      chk_eq("rst_bvalid", 32'(BVALID), 32'd0);
      chk_eq("rst_rvalid", 32'(RVALID), 32'd0);
      chk_eq("rst_rdata", RDATA, 32'd0);
      chk_eq("rst_reg0", reg0_o, 32'd0);
      chk_eq("rst_reg3", reg3_o, 32'd0);
      chk_eq("rst_pulse", 32'(reg_wr_pulse_o), 32'd0);
      ARESETN = 1'b1;
      chk_eq("rel_awready_first", 32'(AWREADY), 32'd0);
      tick();
      chk_eq("rel_awready", 32'(AWREADY), 32'd1);
      chk_eq("rel_arready", 32'(ARREADY), 32'd1);

      // Sequential writes and readback
      axi_write("wr0", 4'h0, 32'h1, 4'hF, 4'b0001);
      axi_write("wr1", 4'h4, 32'h2, 4'hF, 4'b0010);
      axi_write("wr2", 4'h8, 32'h3, 4'hF, 4'b0100);
      axi_write("wr3", 4'hC, 32'h4, 4'hF, 4'b1000);
      axi_read("rd0", 4'h0, 32'h1);
      axi_read("rd1", 4'h4, 32'h2);
      axi_read("rd2", 4'h8, 32'h3);
      axi_read("rd3", 4'hC, 32'h4);
      chk_eq("reg1_seq", reg1_o, 32'h2);

      // W three cycles ahead of AW
      WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1'b1;
      tick();
      WVALID = 1'b0;
      chk_eq("wfirst_wready_drop", 32'(WREADY), 32'd0);
      chk_eq("wfirst_awready", 32'(AWREADY), 32'd1);
      chk_eq("wfirst_no_bvalid", 32'(BVALID), 32'd0);
      tick();
      tick();
      AWADDR = 4'h8; AWVALID = 1'b1;
      chk_eq("wfirst_reg2_before", reg2_o, 32'h3);
      tick();
      AWVALID = 1'b0;
      chk_eq("wfirst_bvalid", 32'(BVALID), 32'd1);
      chk_eq("wfirst_reg2", reg2_o, 32'hDEADBEEF);
      chk_eq("wfirst_pulse", 32'(reg_wr_pulse_o), 32'h4);
      BREADY = 1'b1;
      tick();
      BREADY = 1'b0;
      chk_eq("wfirst_bdone", 32'(BVALID), 32'd0);

      // Byte strobes
      axi_write("strb_all", 4'h4, 32'hFFFFFFFF, 4'hF, 4'b0010);
      axi_write("strb_0101", 4'h5, 32'h12345678, 4'b0101, 4'b0010);
      chk_eq("strb_0101_reg1", reg1_o, 32'hFF34FF78);
      axi_write("strb_none", 4'h4, 32'h0BADF00D, 4'b0000, 4'b0010);
      chk_eq("strb_none_reg1", reg1_o, 32'hFF34FF78);

      // Back-pressure on B and R
      AWADDR = 4'hC; WDATA = 32'h55; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
      ARADDR = 4'h0; ARVALID = 1'b1;
      tick();
      AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
      chk_eq("bp_reg3", reg3_o, 32'h55);
      for (int i = 0; i < 5; i++) begin
         chk_eq("bp_bvalid", 32'(BVALID), 32'd1);
         chk_eq("bp_rvalid", 32'(RVALID), 32'd1);
         chk_eq("bp_rdata", RDATA, 32'h1);
         chk_eq("bp_readies", {29'd0, AWREADY, WREADY, ARREADY}, 32'd0);
         tick();
      end
      BREADY = 1'b1; RREADY = 1'b1;
      tick();
      BREADY = 1'b0; RREADY = 1'b0;
      chk_eq("bp_bdone", 32'(BVALID), 32'd0);
      chk_eq("bp_rdone", 32'(RVALID), 32'd0);

      // Same-edge read and write of one register
      axi_write("same_prep", 4'h4, 32'h2, 4'hF, 4'b0010);
      AWADDR = 4'h4; WDATA = 32'hAA; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
      ARADDR = 4'h4; ARVALID = 1'b1;
      tick();
      AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
      chk_eq("same_rvalid", 32'(RVALID), 32'd1);
      chk_eq("same_rdata_old", RDATA, 32'h2);
      chk_eq("same_bvalid", 32'(BVALID), 32'd1);
      chk_eq("same_reg1", reg1_o, 32'hAA);
      BREADY = 1'b1; RREADY = 1'b1;
      tick();
      BREADY = 1'b0; RREADY = 1'b0;
      axi_read("same_after", 4'h4, 32'hAA);

      // Reset while a write response is pending
      AWADDR = 4'h0; WDATA = 32'h77; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
      tick();
      AWVALID = 1'b0; WVALID = 1'b0;
      chk_eq("mrst_bvalid_pend", 32'(BVALID), 32'd1);
      chk_eq("mrst_reg0_pend", reg0_o, 32'h77);
      tick();
      ARESETN = 1'b0;
      #1;
      chk_eq("mrst_bvalid_drop", 32'(BVALID), 32'd0);
      chk_eq("mrst_reg0", reg0_o, 32'd0);
      chk_eq("mrst_reg1", reg1_o, 32'd0);
      chk_eq("mrst_reg2", reg2_o, 32'd0);
      chk_eq("mrst_reg3", reg3_o, 32'd0);
      repeat (2) tick();
      ARESETN = 1'b1;
      chk_eq("mrst_readies_first", {29'd0, AWREADY, WREADY, ARREADY}, 32'd0);
      BREADY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_eq("mrst_no_stray_b", 32'(BVALID), 32'd0);
      end
      BREADY = 1'b0;
      axi_read("mrst_rd0", 4'h0, 32'h0);
      axi_read("mrst_rd1", 4'h4, 32'h0);
      axi_read("mrst_rd2", 4'h8, 32'h0);
      axi_read("mrst_rd3", 4'hC, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
